// File: rtl/display_scanout.sv
// Raster timing generator and framebuffer scan-out for an RGB565 panel, with render-request tracking.
// Optional build macro SCANOUT_TEST_PATTERN_EN adds a colour-bar test pattern selectable at run time.
module display_scanout #(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 32,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef SCANOUT_TEST_PATTERN_EN
    input  logic                        test_pattern_sel,
`endif
    output logic [$clog2(H_ACTIVE)-1:0] x_out,
    output logic [$clog2(V_ACTIVE)-1:0] y_out,
    input  logic [15:0]                 pixel_in,
    output logic [15:0]                 rgb_out,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic                        frame_start,
    input  logic                        frame_done,
    output logic [7:0]                  late_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          active;
    logic          hsync_stage0;
    logic          vsync_stage0;
    logic [1:0]    de_pipe_reg;
    logic [1:0]    hsync_pipe_reg;
    logic [1:0]    vsync_pipe_reg;
    logic [15:0]   rgb_reg;
    logic [15:0]   pixel_src;
    logic          pending_reg;
    logic [7:0]    late_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        active       = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
        hsync_stage0 = !((h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END));
        vsync_stage0 = !((v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END));
        x_out        = active ? h_cnt_reg[XW-1:0] : '0;
        y_out        = active ? v_cnt_reg[YW-1:0] : '0;
        frame_start  = (h_cnt_reg == '0) && (v_cnt_reg == V_ACT);
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    // Eight equal-width bars, index 0 at the left edge.
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [8*16-1:0] BAR_COLORS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    logic [7:0]  bar_hit;
    logic [15:0] pattern_color;
    logic [15:0] pattern_reg;
    logic        pattern_sel_reg;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bar
        assign bar_hit[gi] = (h_cnt_reg >= HW'(gi * BAR_W));
    end

    always_comb begin
        pattern_color = BAR_COLORS[15:0];
        for (int i = 0; i < 8; i++) begin
            if (bar_hit[i]) begin
                pattern_color = BAR_COLORS[i*16 +: 16];
            end
        end
    end

    // The pattern is computed alongside the framebuffer address so it lands with the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_reg     <= '0;
            pattern_sel_reg <= 1'b0;
        end else begin
            pattern_reg     <= pattern_color;
            pattern_sel_reg <= test_pattern_sel;
        end
    end

    assign pixel_src = pattern_sel_reg ? pattern_reg : pixel_in;
`else
    assign pixel_src = pixel_in;
`endif

    // Two-stage alignment: stage 1 matches the framebuffer read, stage 2 the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_pipe_reg    <= 2'b00;
            hsync_pipe_reg <= 2'b11;
            vsync_pipe_reg <= 2'b11;
            rgb_reg        <= '0;
        end else begin
            de_pipe_reg    <= {de_pipe_reg[0], active};
            hsync_pipe_reg <= {hsync_pipe_reg[0], hsync_stage0};
            vsync_pipe_reg <= {vsync_pipe_reg[0], vsync_stage0};
            rgb_reg        <= de_pipe_reg[0] ? pixel_src : 16'h0000;
        end
    end

    assign rgb_out = rgb_reg;
    assign de      = de_pipe_reg[1];
    assign hsync   = hsync_pipe_reg[1];
    assign vsync   = vsync_pipe_reg[1];

    // A request issued while the previous one is outstanding counts as a missed frame,
    // unless the completion arrives on the same clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= 1'b0;
            late_reg    <= '0;
        end else if (frame_start) begin
            if (pending_reg && !frame_done && (late_reg != 8'hFF)) begin
                late_reg <= late_reg + 8'd1;
            end
            pending_reg <= 1'b1;
        end else if (frame_done) begin
            pending_reg <= 1'b0;
        end
    end

    assign late_count = late_reg;

endmodule

// File: tb/tb_display_scanout.sv
// Randomized bench for display_scanout: per-cycle comparison against a cycle-index timing model,
// a random framebuffer image and a rule-level model of the missed-frame counter.
module tb_display_scanout;

    localparam int HA  = 16;
    localparam int HFP = 1;
    localparam int HS  = 2;
    localparam int HBP = 1;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;
    localparam int XW  = $clog2(HA);
    localparam int YW  = $clog2(VA);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [15:0]   pixel_in = 16'h0000;
    logic [15:0]   rgb_out;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          frame_start;
    logic          frame_done = 1'b0;
    logic [7:0]    late_count;
`ifdef SCANOUT_TEST_PATTERN_EN
    logic          test_pattern_sel = 1'b0;
`endif

    display_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SCANOUT_TEST_PATTERN_EN
        .test_pattern_sel(test_pattern_sel),
`endif
        .x_out       (x_out),
        .y_out       (y_out),
        .pixel_in    (pixel_in),
        .rgb_out     (rgb_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .late_count  (late_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;
    int m_pending   = 0;
    int m_late      = 0;
    int fs_at       = -1000;
    int sel_now     = 0;
    int sel_h1      = 0;
    int sel_h2      = 0;
    bit fs_seen     = 1'b0;
    logic [15:0] fb [1<<YW][1<<XW];

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            if (miscompares <= 25)
                $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic int hpos(input int k); return (k % FT) % HT; endfunction
    function automatic int vpos(input int k); return (k % FT) / HT; endfunction
    function automatic bit act(input int k); return hpos(k) < HA && vpos(k) < VA; endfunction
    function automatic bit fs_model(input int k); return hpos(k) == 0 && vpos(k) == VA; endfunction

    function automatic int bar_color(input int h);
        case (h / (HA / 8))
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_outputs();
        int m;
        int exp_rgb;
        int exp_hs;
        int exp_vs;
        int exp_de;
        check("x_out", x_out, act(n) ? hpos(n) : 0);
        check("y_out", y_out, act(n) ? vpos(n) : 0);
        check("frame_start", frame_start, fs_model(n));
        check("late_count", late_count, m_late);
        exp_rgb = 0; exp_hs = 1; exp_vs = 1; exp_de = 0;
        if (n >= 2) begin
            m      = n - 2;
            exp_de = act(m);
            exp_hs = !(hpos(m) >= HA + HFP && hpos(m) < HA + HFP + HS);
            exp_vs = !(vpos(m) >= VA + VFP && vpos(m) < VA + VFP + VS);
            if (exp_de) exp_rgb = sel_h2 ? bar_color(hpos(m)) : fb[vpos(m)][hpos(m)];
        end
        check("de", de, exp_de);
        check("hsync", hsync, exp_hs);
        check("vsync", vsync, exp_vs);
        check("rgb_out", rgb_out, exp_rgb);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_rgb"}, rgb_out, 0);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_de"}, de, 0);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_late"}, late_count, 0);
    endtask

    // mode 0: random completions, 1: never, 2: coincident with request, 3: prompt return
    task automatic step(input int mode);
        bit          fd;
        bit          fs;
        logic [15:0] pix_next;
        check_outputs();
        fs = fs_model(n);
        if (frame_start && !fs_seen) begin
            fs_seen = 1'b1;
            check("first_frame_start", n, VA * HT);
        end
        if (fs) begin
            fs_at = n;
`ifdef SCANOUT_TEST_PATTERN_EN
            sel_now = $urandom_range(0, 1);
`endif
            $display("frame_start n=%0d mode=%0d late_count=%0d sel=%0d", n, mode, late_count, sel_now);
        end
        case (mode)
            0:       fd = ($urandom_range(0, 63) == 0);
            1:       fd = 1'b0;
            2:       fd = fs;
            default: fd = (n == fs_at + 50);
        endcase
        frame_done = fd;
`ifdef SCANOUT_TEST_PATTERN_EN
        test_pattern_sel = sel_now[0];
`endif
        sel_h2   = sel_h1;
        sel_h1   = sel_now;
        pix_next = fb[y_out][x_out];
        if (fs && fd) m_pending = 1;
        else if (fs) begin
            if (m_pending != 0 && m_late < 255) m_late++;
            m_pending = 1;
        end else if (fd) m_pending = 0;
        n++;
        @(posedge clk);
        #1 pixel_in = pix_next;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int hold);
        frame_done = 1'b0;
        rst        = 1'b0;
        m_pending  = 0;
        m_late     = 0;
        #1 check_reset("rst_async");
        repeat (hold) begin
            @(negedge clk);
            check_reset("rst_hold");
        end
        rst     = 1'b1;
        n       = 0;
        fs_at   = -1000;
        fs_seen = 1'b0;
    endtask

    task automatic run(input int cycles, input int mode);
        repeat (cycles) step(mode);
    endtask

    initial begin
        int late_before;
        foreach (fb[y, x]) fb[y][x] = 16'($urandom);
        @(negedge clk);
        apply_reset(3);
        run(3 * FT, 3);
        check("late_prompt", late_count, 0);
        run(3 * FT, 1);
        late_before = m_late;
        run(2 * FT, 2);
        check("late_coincident", late_count, late_before);
        run(4 * FT, 0);
        run($urandom_range(1, FT - 1), 0);
        apply_reset($urandom_range(1, 5));
        run(262 * FT, 1);
        check("late_saturated", late_count, 255);
        run(2 * FT, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scanout.md
DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 32, H_BP 32, meaning horizontal front porch, sync and back porch in clocks; line total 400.
REQ-003 SHALL have parameters V_ACTIVE 240, V_FP 4, V_SYNC 4, V_BP 12, meaning vertical timing in lines; frame total 260.
REQ-004 SHALL have port clk, input, 1, pixel clock (display_out_clk domain); the only clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port x_out, output, $clog2(H_ACTIVE), framebuffer read column.
REQ-007 SHALL have port y_out, output, $clog2(V_ACTIVE), framebuffer read row.
REQ-008 SHALL have port pixel_in, input, 16, RGB565 framebuffer read data, valid one clk after x_out/y_out.
REQ-009 SHALL have port rgb_out, output, 16, RGB565 to panel.
REQ-010 SHALL have ports hsync and vsync, output, 1 each, active-low syncs.
REQ-011 SHALL have port de, output, 1, data enable.
REQ-012 SHALL have port frame_start, output, 1, one-clk render request pulse.
REQ-013 SHALL have port frame_done, input, 1, renderer completion pulse.
REQ-014 SHALL have port late_count, output, 8, count of missed frames.

Function
REQ-015 SHALL keep h_cnt 0..399 and v_cnt 0..259; h_cnt wraps 399->0 and increments v_cnt; v_cnt wraps 259->0 on the same clk as h_cnt wrap.
REQ-016 SHALL define active as h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-017 SHALL drive x_out=h_cnt, y_out=v_cnt combinationally while active, else 0.
REQ-018 SHALL define stage-0 hsync low for h_cnt in [336,367], vsync low for v_cnt in [244,247], de=active.
REQ-019 SHALL register pixel_in into rgb_out one clk after arrival; rgb_out total latency 2 clks from counter value.
REQ-020 SHALL delay hsync, vsync and de by two registers so they align with rgb_out.
REQ-021 SHALL force rgb_out=0 whenever its aligned de is 0.
REQ-022 SHALL pulse frame_start for exactly one clk at h_cnt=0, v_cnt=V_ACTIVE (first blank line).
REQ-023 SHALL hold a pending flag: set by frame_start, cleared by frame_done.
REQ-024 SHALL, when frame_start fires while pending is still set, increment late_count saturating at 255; pending stays set.
REQ-025 SHALL give frame_done priority loss on simultaneous frame_done and frame_start: clear then set, no increment.
REQ-026 SHALL ignore frame_done while pending is clear.

Reset
REQ-027 SHALL on rst low clear h_cnt, v_cnt, pending, late_count, rgb_out, all delay stages; hsync=vsync=1, de=0, frame_start=0.
REQ-028 SHALL, after rst rises mid-frame, restart at pixel (0,0); first frame_start 240*400 clks after release.

Configuration
REQ-029 SHALL, with SCANOUT_TEST_PATTERN_EN defined, add input test_pattern_sel (1 bit); when high rgb_out shows 8 vertical bars of 40 px each (white, yellow, cyan, green, magenta, red, blue, black in RGB565) with pixel_in ignored, same latency and de gating.
REQ-030 SHALL, without SCANOUT_TEST_PATTERN_EN, omit test_pattern_sel and always output framebuffer data.

Verification
REQ-031 Reset release, run 2 frames -> hsync period 400 clks low 32; vsync period 104000 clks low 1600; de high 320 clks x 240 lines.
REQ-032 pixel_in driven = {x_out[6:0],y_out[7:0],1'b1} delayed 1 clk -> rgb_out at aligned de for (5,7) equals 16'h0A0F; rgb_out=0 in blanking.
REQ-033 frame_done returned 1000 clks after each frame_start -> late_count stays 0; omit frame_done 3 frames -> late_count=2.
REQ-034 frame_done coincident with frame_start -> late_count unchanged, pending set; force 300 missed frames -> late_count=255.
REQ-035 rst pulsed low at (100,50) -> outputs reset immediately; first de after release at (0,0); frame_start 96000 clks after release.
REQ-036 With SCANOUT_TEST_PATTERN_EN, test_pattern_sel=1 -> x 0..39 rgb_out=16'hFFFF, x 280..319 rgb_out=16'h0000.
